serial_word_transmitter: RTL

//   Parallel-to-serial framing transmitter feeding the serial input (sln) of the

---
 rtl/serial_word_transmitter_pkg.sv | 20 ++
 rtl/serial_word_transmitter_bit_period_timer.sv | 37 +++
 rtl/serial_word_transmitter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_word_transmitter_pkg.sv
// Shared types for the serial word transmitter.
// FSM state encoding and counter sizing helper.
package serial_word_transmitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int unsigned cnt_width(
    input int unsigned n
  );
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_word_transmitter_bit_period_timer.sv
// Bit period tick counter for the serial word transmitter.
// Flags the last clock of every CYCLES_PER_BIT-long period while running.
module bit_period_timer
  import serial_word_transmitter_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic period_end
);

  localparam int unsigned TW = cnt_width(CYCLES_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CYCLES_PER_BIT - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign period_end = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (!run || period_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_transmitter.sv
// Framing transmitter: start bit, N data bits MSB first,
// optional even parity, then stop bits on an idle-high line.
module serial_word_transmitter
  import serial_word_transmitter_pkg::*;
#(
  parameter int unsigned N              = 8,
  parameter int unsigned CYCLES_PER_BIT = 4,
  parameter int unsigned PARITY_EN      = 1,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] din,
  output logic         sout,
  output logic         shift_en,
  output logic         busy,
  output logic         done
);

  localparam int unsigned BW = cnt_width(N + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(N - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_e        state_q;
  state_e        state_d;
  logic [N-1:0]  shreg_q;
  logic [N-1:0]  shreg_d;
  logic          par_q;
  logic          par_d;
  logic [BW-1:0] bit_q;
  logic [BW-1:0] bit_d;
  logic          period_end;
  logic          running;

  assign running = (state_q != ST_IDLE);

  bit_period_timer #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (running),
    .period_end(period_end)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    bit_d   = bit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d = ST_START;
          shreg_d = din;
          par_d   = ^din;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (period_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (period_end) begin
          shreg_d = shreg_q << 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY
                                       : ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (period_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (period_end) begin
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
    end
  end

  // Outputs decode only flops, so din/load_valid never reach sout.
  always_comb begin
    sout = 1'b1;
    unique case (state_q)
      ST_START:  sout = 1'b0;
      ST_DATA:   sout = shreg_q[N-1];
      ST_PARITY: sout = par_q;
      default:   sout = 1'b1;
    endcase
  end

  assign shift_en   = (state_q == ST_DATA) && period_end;
  assign done       = (state_q == ST_STOP) && period_end
                   && (bit_q == LAST_STOP);
  assign busy       = running;
  assign load_ready = !running;

endmodule
